// File: rtl/hilo_ctrl.sv
// rtl/hilo_ctrl.sv - HI/LO sequencing and storage behind mul_div; optional HILO_FWD_EN forwards the completing result
module hilo_ctrl #(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        md_start,
    input  logic [1:0]  md_op,
    input  logic        md_cancel,
    input  logic [31:0] md_l32,
    input  logic [31:0] md_h32,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    input  logic        mfhi,
    input  logic        mflo,
    output logic [1:0]  op_q,
    output logic        stall,
    output logic [31:0] rdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);
    localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT);
    localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          req_md;
    logic          req_mf;

    assign req_md = md_start | mthi | mtlo;
    assign req_mf = mfhi | mflo;

    // Forwarding lets reads complete in DONE; writers and new ops always wait for IDLE.
`ifdef HILO_FWD_EN
    assign stall = ((state == BUSY) & (req_md | req_mf)) | ((state == DONE) & req_md);
`else
    assign stall = (state != IDLE) & (req_md | req_mf);
`endif

    always_comb begin
        rdata = '0;
`ifdef HILO_FWD_EN
        if (mfhi)
            rdata = (state == DONE) ? md_h32 : hi;
        else if (mflo)
            rdata = (state == DONE) ? md_l32 : lo;
`else
        if (mfhi)
            rdata = hi;
        else if (mflo)
            rdata = lo;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            op_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mthi)
                        hi <= wdata;
                    if (mtlo)
                        lo <= wdata;
                    if (md_start && !md_cancel) begin
                        op_q  <= md_op;
                        cnt   <= md_op[1] ? DIV_CNT : MUL_CNT;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (md_cancel) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                        if (cnt == CNT_ONE)
                            state <= DONE;
                    end
                end
                DONE: begin
                    if (!md_cancel) begin
                        hi <= md_h32;
                        lo <= md_l32;
                    end
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_ctrl.sv
// tb/tb_hilo_ctrl.sv - scoreboard bench for hilo_ctrl with a behavioural mul_div in front
module tb_hilo_ctrl;

    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 8;
    localparam logic [1:0] MD_MULT  = 2'd0;
    localparam logic [1:0] MD_MULTU = 2'd1;
    localparam logic [1:0] MD_DIV   = 2'd2;
    localparam logic [1:0] MD_DIVU  = 2'd3;
`ifdef HILO_FWD_EN
    localparam int RD_EXTRA = 0;
`else
    localparam int RD_EXTRA = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        md_start, md_cancel, mthi, mtlo, mfhi, mflo;
    logic [1:0]  md_op, op_q;
    logic [31:0] md_l32, md_h32, wdata, rdata, hi, lo;
    logic        stall;
    logic [31:0] da, db;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    hilo_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .md_start(md_start), .md_op(md_op),
        .md_cancel(md_cancel), .md_l32(md_l32), .md_h32(md_h32),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .mfhi(mfhi), .mflo(mflo),
        .op_q(op_q), .stall(stall), .rdata(rdata), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Upstream mul_div stand-in: combinational on latched op and held operands.
    always_comb begin
        logic signed [63:0] sp;
        logic        [63:0] up;
        sp = $signed({{32{da[31]}}, da}) * $signed({{32{db[31]}}, db});
        up = {32'd0, da} * {32'd0, db};
        md_l32 = '0;
        md_h32 = '0;
        case (op_q)
            MD_MULT:  {md_h32, md_l32} = sp;
            MD_MULTU: {md_h32, md_l32} = up;
            MD_DIV: begin
                if (db != 0) begin
                    md_l32 = $signed(da) / $signed(db);
                    md_h32 = $signed(da) % $signed(db);
                end
            end
            default: begin
                if (db != 0) begin
                    md_l32 = da / db;
                    md_h32 = da % db;
                end
            end
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic count_stall(output int n);
        n = 0;
        @(negedge clk);
        while (stall && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) check("stall_timeout", 32'(n), 32'd0);
    endtask

    // Monitor: every accepted read pops one expected value.
    always @(negedge clk) begin
        if (rst_n && (mfhi || mflo) && !stall) begin
            if (exp_q.size() == 0)
                check("sb_unexpected_read", rdata, 32'hDEADBEEF);
            else
                check("sb_rdata", rdata, exp_q.pop_front());
        end
    end

    initial begin
        int n;
        rst_n = 1'b0; md_start = 0; md_op = 0; md_cancel = 0;
        mthi = 0; mtlo = 0; mfhi = 0; mflo = 0; wdata = 0; da = 0; db = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_op_q", {30'd0, op_q}, 0);
        mfhi = 1;
        #0 check("rst_stall", {31'd0, stall}, 0);
        exp_q.push_back(32'h0);
        tick();
        mfhi = 0;

        // MULT -3*5, mflo held until it is served
        da = 32'hFFFFFFFD; db = 32'd5; md_op = MD_MULT; md_start = 1;
        tick();
        md_start = 0; mflo = 1;
        exp_q.push_back(32'hFFFFFFF1);
        count_stall(n);
        check("mult_stall_cycles", 32'(n), 32'(MUL_LAT + RD_EXTRA));
        tick();
        mflo = 0;
        check("mult_lo", lo, 32'hFFFFFFF1);
        check("mult_hi", hi, 32'hFFFFFFFF);

        // MULTU 0xFFFFFFFF*2, result lands only at E_LAT+1
        da = 32'hFFFFFFFF; db = 32'd2; md_op = MD_MULTU; md_start = 1;
        tick();
        md_start = 0;
        for (int i = 0; i < MUL_LAT; i++) begin
            check("multu_op_q", {30'd0, op_q}, {30'd0, MD_MULTU});
            tick();
        end
        check("multu_op_q_done", {30'd0, op_q}, {30'd0, MD_MULTU});
        check("multu_hi_not_yet", hi, 32'hFFFFFFFF);
        tick();
        check("multu_hi", hi, 32'h00000001);
        check("multu_lo", lo, 32'hFFFFFFFE);

        // DIV -7/2 with md_start held: second start waits for IDLE, then is cancelled
        da = 32'hFFFFFFF9; db = 32'd2; md_op = MD_DIV; md_start = 1;
        tick();
        count_stall(n);
        check("div_b2b_stall", 32'(n), 32'(DIV_LAT + 1));
        check("div_lo", lo, 32'hFFFFFFFD);
        check("div_hi", hi, 32'hFFFFFFFF);
        tick();
        md_start = 0; md_cancel = 1;
        tick();
        md_cancel = 0; mfhi = 1;
        #0 check("div_cancel_stall", {31'd0, stall}, 0);
        exp_q.push_back(32'hFFFFFFFF);
        tick();
        mfhi = 0;

        // DIV 100/7 with mfhi issued at E2
        da = 32'd100; db = 32'd7; md_op = MD_DIV; md_start = 1;
        tick();
        md_start = 0;
        tick();
        mfhi = 1;
        exp_q.push_back(32'd2);
        count_stall(n);
        check("mfhi_e2_stall", 32'(n), 32'(DIV_LAT - 1 + RD_EXTRA));
        tick();
        mfhi = 0;
        check("div2_hi", hi, 32'd2);
        check("div2_lo", lo, 32'd14);

        // mthi, then MULT cancelled at E3: HI kept, nothing captured later
        wdata = 32'h12345678; mthi = 1;
        tick();
        mthi = 0;
        da = 32'd3; db = 32'd4; md_op = MD_MULT; md_start = 1;
        tick();
        md_start = 0;
        tick();
        tick();
        md_cancel = 1;
        tick();
        md_cancel = 0; mfhi = 1;
        #0 check("cancel_stall", {31'd0, stall}, 0);
        exp_q.push_back(32'h12345678);
        tick();
        mfhi = 0;
        repeat (3) tick();
        check("cancel_hi_kept", hi, 32'h12345678);
        check("cancel_lo_kept", lo, 32'd14);

        // mthi+mtlo together, both-read priority, no read gives zero
        wdata = 32'hCAFEF00D; mthi = 1; mtlo = 1;
        tick();
        mthi = 0; mtlo = 0;
        check("mt_both_lo", lo, 32'hCAFEF00D);
        mfhi = 1; mflo = 1;
        exp_q.push_back(32'hCAFEF00D);
        tick();
        mfhi = 0; mflo = 0;
        #0 check("rdata_none", rdata, 0);

        // md_cancel in IDLE suppresses a same-cycle md_start
        md_op = MD_MULT; md_start = 1; md_cancel = 1;
        tick();
        md_start = 0; md_cancel = 0; mflo = 1;
        #0 check("idle_cancel_stall", {31'd0, stall}, 0);
        exp_q.push_back(32'hCAFEF00D);
        tick();
        mflo = 0;

        // Asynchronous reset in the middle of BUSY
        da = 32'd9; db = 32'd9; md_op = MD_MULTU; md_start = 1;
        tick();
        md_start = 0;
        tick();
        mthi = 1; wdata = 32'hA5A5A5A5;
        #1 check("busy_stall_pre", {31'd0, stall}, 1);
        rst_n = 0;
        #1;
        check("midrst_hi", hi, 0);
        check("midrst_lo", lo, 0);
        check("midrst_stall", {31'd0, stall}, 0);
        tick();
        rst_n = 1;
        tick();
        mthi = 0;
        check("postrst_mthi", hi, 32'hA5A5A5A5);
        check("postrst_lo", lo, 0);

        repeat (2) tick();
        check("sb_drain", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
